led_mode_ctrl: RTL

//  Sequences the board LED through display modes, driven by debounced single-cycle key pulses

---
 rtl/led_mode_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: LED mode scheduler (off, on, slow/fast blink) driven by debounced key pulses;
// define LED_BREATHE_EN to add mode 4, a triangle-duty PWM breathe.
module led_mode_ctrl #(
  parameter int SLOW_DIV       = 25_000_000,
  parameter int FAST_DIV       = 5_000_000,
  parameter int PWM_BITS       = 8,
  parameter int BREATHE_STEP   = 195_312,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       key_next,
  input  logic       key_prev,
  output logic       led,
  output logic [2:0] mode,
  output logic       mode_chg
);
  localparam int CW = $clog2(SLOW_DIV);
  localparam logic [CW-1:0] SLOW_MAX = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] FAST_MAX = CW'(FAST_DIV - 1);
  localparam logic DARK = LED_ACTIVE_LOW;
`ifdef LED_BREATHE_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif
  typedef enum logic [2:0] {OFF, ON, BLINK_SLOW, BLINK_FAST, BREATHE} mode_t;
  if (FAST_DIV < 2 || FAST_DIV > SLOW_DIV || PWM_BITS < 1 || BREATHE_STEP < 1) begin : g_bad_cfg
    $error("led_mode_ctrl: invalid parameter set");
  end
  mode_t         r_mode;
  logic          r_mode_chg;
  logic          r_led;
  logic          r_phase;
  logic [CW-1:0] r_cnt;
  logic          w_chg;
  logic          w_blink;
  logic          w_wrap;
  logic          w_lit;
  mode_t         w_next;
  assign w_chg   = key_next ^ key_prev;
  assign w_blink = (r_mode == BLINK_SLOW) || (r_mode == BLINK_FAST);
  assign w_wrap  = r_cnt == ((r_mode == BLINK_FAST) ? FAST_MAX : SLOW_MAX);
  assign w_next  = key_next ? ((r_mode == LAST) ? OFF : mode_t'(r_mode + 3'd1))
                            : ((r_mode == OFF) ? mode_t'(LAST) : mode_t'(r_mode - 3'd1));
`ifdef LED_BREATHE_EN
  localparam int SW = $clog2(BREATHE_STEP + 1);
  localparam logic [SW-1:0]       STEP_MAX = SW'(BREATHE_STEP - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] r_duty;
  logic [SW-1:0]       r_step;
  logic                r_dir;
  assign w_lit = (r_mode == ON) || (w_blink && !r_phase) || ((r_mode == BREATHE) && (r_pwm < r_duty));
  // r_dir: 0 = duty rising, 1 = falling; it flips on the step that lands on an endpoint
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pwm  <= '0;
      r_duty <= '0;
      r_step <= '0;
      r_dir  <= 1'b0;
    end else if (!en || w_chg || r_mode != BREATHE) begin
      r_pwm  <= '0;
      r_duty <= '0;
      r_step <= '0;
      r_dir  <= 1'b0;
    end else begin
      r_pwm  <= r_pwm + 1'b1;
      r_step <= (r_step == STEP_MAX) ? '0 : r_step + 1'b1;
      if (r_step == STEP_MAX) begin
        r_duty <= r_dir ? r_duty - 1'b1 : r_duty + 1'b1;
        r_dir  <= r_dir ? (r_duty != DUTY_ONE) : (r_duty == DUTY_MAX - 1'b1);
      end
    end
`else
  assign w_lit = (r_mode == ON) || (w_blink && !r_phase);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mode     <= OFF;
      r_mode_chg <= 1'b0;
      r_led      <= DARK;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_mode_chg <= en && w_chg;
      r_led      <= (en && w_lit) ? ~DARK : DARK;
      if (en && w_chg)
        r_mode <= w_next;
      if (!en || w_chg || !w_blink) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (w_wrap) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else
        r_cnt <= r_cnt + 1'b1;
    end
  assign led      = r_led;
  assign mode     = r_mode;
  assign mode_chg = r_mode_chg;
endmodule
